operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 8 +
 rtl/operand_fetch_fwd_mux.sv | 26 ++
 rtl/operand_fetch.sv | 101 ++++++++++
 tb/tb_operand_fetch.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared constants for the operand-fetch stage: datapath widths and
// register-index encoding.
package operand_fetch_pkg;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int REG_W  = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// Per-source operand selector: x0, then EX forward (non-load), then WB
// forward, then register-bank data.
module fwd_mux #(
  parameter int XLEN = operand_fetch_pkg::XLEN
) (
  input  logic [operand_fetch_pkg::REG_W-1:0] idx,
  input  logic [XLEN-1:0]                     bank_data,
  input  logic                                ex_wen,
  input  logic                                ex_is_load,
  input  logic [operand_fetch_pkg::REG_W-1:0] ex_rd,
  input  logic [XLEN-1:0]                     ex_result,
  input  logic                                wb_wen,
  input  logic [operand_fetch_pkg::REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]                     wb_data,
  output logic [XLEN-1:0]                     data
);
  import operand_fetch_pkg::*;

  // A load in EX has no data yet; the hazard logic stalls instead.
  always_comb begin
    data = bank_data;
    if (idx == ZERO_REG)                           data = '0;
    else if (ex_wen && !ex_is_load && ex_rd == idx) data = ex_result;
    else if (wb_wen && wb_rd == idx)                data = wb_data;
  end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register bank, resolves forwarding and
// load-use hazards, and registers the operand bundle toward execute.
module operand_fetch #(
  parameter int XLEN   = operand_fetch_pkg::XLEN,
  parameter int CTRL_W = operand_fetch_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [4:0]        read_reg1,
  output logic [4:0]        read_reg2,
  input  logic [XLEN-1:0]   read_data1,
  input  logic [XLEN-1:0]   read_data2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_wen,
  input  logic              ex_is_load,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [4:0]        wb_rd,
  input  logic              wb_wen,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       stall_cnt
);
  import operand_fetch_pkg::*;

  localparam int NSRC = 2;

  logic [NSRC-1:0][REG_W-1:0] src_idx;
  logic [NSRC-1:0][XLEN-1:0]  bank_data;
  logic [NSRC-1:0][XLEN-1:0]  fwd_data;
  logic                       hazard;
  logic                       capture;

  assign read_reg1 = in_rs1;
  assign read_reg2 = in_rs2;
  assign src_idx   = {in_rs2, in_rs1};
  assign bank_data = {read_data2, read_data1};

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    fwd_mux #(.XLEN(XLEN)) u_fwd (
      .idx        (src_idx[s]),
      .bank_data  (bank_data[s]),
      .ex_wen     (ex_wen),
      .ex_is_load (ex_is_load),
      .ex_rd      (ex_rd),
      .ex_result  (ex_result),
      .wb_wen     (wb_wen),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .data       (fwd_data[s])
    );
  end

  assign hazard   = in_valid && ex_wen && ex_is_load && (ex_rd != ZERO_REG) &&
                    (ex_rd == in_rs1 || ex_rd == in_rs2);
  assign in_ready = !hazard && !flush && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready;

  // in_ready already excludes flush, so capture and flush never coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_imm   <= '0;
      out_pc    <= '0;
      out_rd    <= '0;
      out_ctrl  <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (capture)   out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (capture) begin
        out_op1  <= fwd_data[0];
        out_op2  <= fwd_data[1];
        out_imm  <= in_imm;
        out_pc   <= in_pc;
        out_rd   <= in_rd;
        out_ctrl <= in_ctrl;
      end
      if (hazard && !flush && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand-built stall /
// backpressure / reset sequences, then random traffic against a reference model.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd, read_reg1, read_reg2, ex_rd, wb_rd, out_rd;
  logic [31:0] in_imm, in_pc, read_data1, read_data2, ex_result, wb_data;
  logic [31:0] out_op1, out_op2, out_imm, out_pc;
  logic        ex_wen, ex_is_load, wb_wen;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [15:0] stall_cnt;

  logic [31:0] bank [32];
  int checks = 0;
  int errors = 0;

  // reference-model state
  logic        m_valid;
  logic [31:0] m_op1, m_op2, m_imm, m_pc;
  logic [4:0]  m_rd;
  logic [7:0]  m_ctrl;
  int          m_stall;

  always #5 clk = ~clk;

  assign read_data1 = bank[read_reg1];
  assign read_data2 = bank[read_reg2];

  operand_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .in_pc(in_pc), .in_ctrl(in_ctrl), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2), .ex_rd(ex_rd),
    .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_result(ex_result),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1),
    .out_op2(out_op2), .out_imm(out_imm), .out_pc(out_pc), .out_rd(out_rd),
    .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_imm = 0; in_pc = 0;
    in_ctrl = 0; ex_rd = 0; ex_wen = 0; ex_is_load = 0; ex_result = 0;
    wb_rd = 0; wb_wen = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    #2 rst = 1;
    m_valid = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_pc = 0; m_rd = 0;
    m_ctrl = 0; m_stall = 0;
  endtask

  // Operand selection written directly from the priority rules.
  function automatic logic [31:0] ref_op(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (ex_wen && !ex_is_load && ex_rd == idx) return ex_result;
    if (wb_wen && wb_rd == idx) return wb_data;
    return bank[idx];
  endfunction

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        ex_wen, ex_ld;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_dat;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t vt [8];

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = 32'h100 + i;
    bank[0] = 32'hDEAD;  // the stage must ignore bank data for x0
    bank[5] = 32'h5;

    vt[0] = '{5'd5,  5'd6,  0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,    32'h5,    32'h106};
    vt[1] = '{5'd5,  5'd7,  1, 0, 5'd5,  32'hAA, 1, 5'd5,  32'hBB,   32'hAA,   32'h107};
    vt[2] = '{5'd0,  5'd9,  0, 0, 5'd0,  32'h0,  1, 5'd0,  32'hFF,   32'h0,    32'h109};
    vt[3] = '{5'd4,  5'd4,  0, 0, 5'd0,  32'h0,  1, 5'd4,  32'h44,   32'h44,   32'h44};
    vt[4] = '{5'd8,  5'd3,  1, 0, 5'd3,  32'h33, 0, 5'd0,  32'h0,    32'h108,  32'h33};
    vt[5] = '{5'd10, 5'd11, 1, 1, 5'd12, 32'h99, 1, 5'd10, 32'h1010, 32'h1010, 32'h10B};
    vt[6] = '{5'd0,  5'd0,  1, 0, 5'd0,  32'hEE, 1, 5'd0,  32'hFF,   32'h0,    32'h0};
    vt[7] = '{5'd2,  5'd1,  0, 0, 5'd2,  32'h77, 1, 5'd2,  32'h22,   32'h22,   32'h101};

    // reset state
    idle();
    #1;
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_stall", {16'b0, stall_cnt}, 32'h0);
    chk("reset_op1", out_op1, 32'h0);
    do_reset();

    // directed vector table, back-to-back at one per cycle
    for (int i = 0; i < 8; i++) begin
      idle();
      in_valid = 1; in_rs1 = vt[i].rs1; in_rs2 = vt[i].rs2;
      in_rd = 5'(i + 1); in_imm = 32'h1000 + i; in_pc = 32'h4000 + 4 * i;
      in_ctrl = 8'(8'hA0 + i);
      ex_wen = vt[i].ex_wen; ex_is_load = vt[i].ex_ld; ex_rd = vt[i].ex_rd;
      ex_result = vt[i].ex_res; wb_wen = vt[i].wb_wen; wb_rd = vt[i].wb_rd;
      wb_data = vt[i].wb_dat;
      #1;
      chk("vec_in_ready", {31'b0, in_ready}, 32'h1);
      chk("vec_read_reg1", {27'b0, read_reg1}, {27'b0, vt[i].rs1});
      chk("vec_read_reg2", {27'b0, read_reg2}, {27'b0, vt[i].rs2});
      @(posedge clk); #1;
      chk("vec_valid", {31'b0, out_valid}, 32'h1);
      chk("vec_op1", out_op1, vt[i].e1);
      chk("vec_op2", out_op2, vt[i].e2);
      chk("vec_imm", out_imm, 32'h1000 + i);
      chk("vec_pc", out_pc, 32'h4000 + 4 * i);
      chk("vec_rd", {27'b0, out_rd}, i + 1);
      chk("vec_ctrl", {24'b0, out_ctrl}, 32'hA0 + i);
    end
    idle();
    @(posedge clk); #1;
    chk("drain_valid", {31'b0, out_valid}, 32'h0);

    // load-use stall for two cycles, then the load lands in WB
    do_reset();
    for (int c = 0; c < 2; c++) begin
      idle();
      in_valid = 1; in_rs1 = 5'd6; in_rs2 = 5'd3; in_imm = 32'h3;
      ex_wen = 1; ex_is_load = 1; ex_rd = 5'd3; ex_result = 32'hBAD;
      #1;
      chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
      @(posedge clk); #1;
      chk("stall_valid", {31'b0, out_valid}, 32'h0);
    end
    chk("stall_cnt2", {16'b0, stall_cnt}, 32'h2);
    ex_wen = 0; ex_is_load = 0; wb_wen = 1; wb_rd = 5'd3; wb_data = 32'h3333;
    #1;
    chk("stall_release_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;
    chk("stall_cap_valid", {31'b0, out_valid}, 32'h1);
    chk("stall_cap_op2", out_op2, 32'h3333);
    chk("stall_cnt_hold", {16'b0, stall_cnt}, 32'h2);

    // backpressure for three cycles, then flush while still not ready
    do_reset();
    idle();
    in_valid = 1; in_rs1 = 5'd5; in_imm = 32'hA; in_pc = 32'h40;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      idle();
      out_ready = 0; in_valid = 1; in_rs1 = 5'd9; in_imm = 32'hB; in_pc = 32'h44;
      #1;
      chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
      @(posedge clk); #1;
      chk("bp_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_op1", out_op1, 32'h5);
      chk("bp_imm", out_imm, 32'hA);
      chk("bp_pc", out_pc, 32'h40);
    end
    flush = 1;
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'h0);
    @(posedge clk); #1;
    chk("flush_valid", {31'b0, out_valid}, 32'h0);

    // asynchronous reset with a held instruction and stall_cnt=7
    do_reset();
    idle();
    in_valid = 1; in_rs1 = 5'd5; in_imm = 32'h77;
    @(posedge clk); #1;
    idle();
    out_ready = 0; in_valid = 1; in_rs2 = 5'd3; ex_wen = 1; ex_is_load = 1; ex_rd = 5'd3;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_stall", {16'b0, stall_cnt}, 32'h7);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    #2 rst = 0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("async_rst_stall", {16'b0, stall_cnt}, 32'h0);
    chk("async_rst_op1", out_op1, 32'h0);
    chk("async_rst_imm", out_imm, 32'h0);
    idle();
    #1 rst = 1;
    @(posedge clk); #1;
    chk("post_rst_no_capture", {31'b0, out_valid}, 32'h0);

    // random traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic m_haz, m_rdy, m_cap;
      logic [31:0] s1, s2;
      in_valid   = 1'($urandom_range(3, 0) != 0);
      in_rs1     = 5'($urandom_range(7, 0));
      in_rs2     = 5'($urandom_range(7, 0));
      in_rd      = 5'($urandom_range(31, 0));
      in_imm     = $urandom;
      in_pc      = $urandom;
      in_ctrl    = 8'($urandom);
      ex_wen     = 1'($urandom_range(1, 0));
      ex_is_load = 1'($urandom_range(3, 0) == 0);
      ex_rd      = 5'($urandom_range(7, 0));
      ex_result  = $urandom;
      wb_wen     = 1'($urandom_range(1, 0));
      wb_rd      = 5'($urandom_range(7, 0));
      wb_data    = $urandom;
      flush      = 1'($urandom_range(15, 0) == 0);
      out_ready  = 1'($urandom_range(3, 0) != 0);
      #1;
      m_haz = in_valid && ex_wen && ex_is_load && ex_rd != 0 &&
              (ex_rd == in_rs1 || ex_rd == in_rs2);
      m_rdy = !m_haz && !flush && (!m_valid || out_ready);
      m_cap = in_valid && m_rdy;
      s1 = ref_op(in_rs1);
      s2 = ref_op(in_rs2);
      chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
      @(posedge clk);
      if (flush) m_valid = 0;
      else if (m_cap) m_valid = 1;
      else if (out_ready) m_valid = 0;
      if (m_cap) begin
        m_op1 = s1; m_op2 = s2; m_imm = in_imm; m_pc = in_pc;
        m_rd = in_rd; m_ctrl = in_ctrl;
      end
      if (m_haz && !flush && m_stall < 65535) m_stall++;
      #1;
      chk("rnd_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("rnd_op1", out_op1, m_op1);
      chk("rnd_op2", out_op2, m_op2);
      chk("rnd_imm", out_imm, m_imm);
      chk("rnd_pc", out_pc, m_pc);
      chk("rnd_rd", {27'b0, out_rd}, {27'b0, m_rd});
      chk("rnd_ctrl", {24'b0, out_ctrl}, {24'b0, m_ctrl});
      chk("rnd_stall", {16'b0, stall_cnt}, 32'(m_stall));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
